// File: rtl/td4_pkg.sv
// Shared definitions for the TD4 program memory / instruction-fetch block.
//   state_e      : two-state controller (RUN fetches, LOAD fills memory)
//   PROG_DEPTH   : number of program words, tied to the 4-bit program counter
//   NOP_WORD     : word presented to the CPU while loading and after reset
//   instr_t      : one program word, immediate in the upper nibble, opcode below
package td4_pkg;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_LOAD = 1'b1
    } state_e;

    localparam int         PROG_DEPTH = 16;
    localparam logic [7:0] NOP_WORD   = 8'h00;

    typedef struct packed {
        logic [3:0] imm;
        logic [3:0] op;
    } instr_t;

endpackage : td4_pkg

// File: rtl/td4_prog_mem_if.sv
// Bus between the TD4 program memory and whatever drives it (load pins + CPU).
//   load_en, wr_strobe : asynchronous pin inputs controlling LOAD mode
//   wr_data            : byte to write, [3:0] opcode, [7:4] immediate
//   pc                 : CPU program counter
//   opcode, immediate  : instruction fields returned to the CPU
//   cpu_hold           : CPU must stall while high
//   load_addr          : next address LOAD will write
//   loaded             : all words written during the current LOAD session
// modport slave  : the program memory
// modport master : the driving side (pins / CPU / testbench)
interface td4_prog_mem_if;

    logic       load_en;
    logic       wr_strobe;
    logic [7:0] wr_data;
    logic [3:0] pc;
    logic [3:0] opcode;
    logic [3:0] immediate;
    logic       cpu_hold;
    logic [3:0] load_addr;
    logic       loaded;

    modport master (
        output load_en, wr_strobe, wr_data, pc,
        input  opcode, immediate, cpu_hold, load_addr, loaded
    );

    modport slave (
        input  load_en, wr_strobe, wr_data, pc,
        output opcode, immediate, cpu_hold, load_addr, loaded
    );

endinterface : td4_prog_mem_if

// File: rtl/td4_prog_mem_sync_rise.sv
// Two-flop synchronizer for an asynchronous pin followed by a rising-edge
// detector.
//   clk, rst_n : clock, asynchronous active-low reset (all flops clear to 0)
//   d          : asynchronous input
//   level      : synchronized level (two cycles behind the pin)
//   rise       : one-cycle pulse when level goes 0 -> 1
module sync_rise (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic rise
);

    logic sync1_d, sync1_q;
    logic sync2_d, sync2_q;
    logic prev_d,  prev_q;

    // The edge history follows the synchronized level on every cycle, so a
    // level that was already high when a consumer starts listening never
    // produces a pulse.
    always_comb begin
        sync1_d = d;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge values; blocking here would collapse the synchronizer chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign level = sync2_q;
    assign rise  = sync2_q & ~prev_q;

endmodule : sync_rise

// File: rtl/td4_prog_mem.sv
// Writable 16x8 program memory and instruction-fetch stage for the TD4 CPU.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : td4_prog_mem_if.slave
//       RUN  : opcode/immediate read combinationally from mem[pc]
//       LOAD : outputs forced to NOP_WORD, cpu_hold high, each synchronized
//              rising edge of wr_strobe writes wr_data at load_addr
// Reset clears every word to NOP_WORD and returns to RUN.
module td4_prog_mem
    import td4_pkg::*;
#(
    parameter int         DEPTH    = PROG_DEPTH,
    parameter logic [7:0] NOP_WORD = td4_pkg::NOP_WORD
) (
    input  logic             clk,
    input  logic             rst_n,
    td4_prog_mem_if.slave    bus
);

    logic load_lvl;
    logic load_en_rise_unused;
    logic strobe_lvl_unused;
    logic strobe_rise;

    sync_rise u_sync_load (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.load_en),
        .level (load_lvl),
        .rise  (load_en_rise_unused)
    );

    sync_rise u_sync_strobe (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.wr_strobe),
        .level (strobe_lvl_unused),
        .rise  (strobe_rise)
    );

    state_e     state_d,     state_q;
    logic [3:0] load_addr_d, load_addr_q;
    logic [4:0] wr_cnt_d,    wr_cnt_q;
    instr_t     mem_d [DEPTH];
    instr_t     mem_q [DEPTH];

    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        load_addr_d = load_addr_q;
        wr_cnt_d    = wr_cnt_q;
        mem_d       = mem_q;

        unique case (state_q)
            ST_RUN: begin
                // Strobe edges are ignored here; entry starts a fresh session.
                if (load_lvl) begin
                    state_d     = ST_LOAD;
                    load_addr_d = 4'd0;
                    wr_cnt_d    = 5'd0;
                end
            end
            ST_LOAD: begin
                // Leaving takes priority over a strobe edge in the same cycle.
                if (!load_lvl) begin
                    state_d = ST_RUN;
                end else if (strobe_rise) begin
                    mem_d[load_addr_q] = instr_t'(bus.wr_data);
                    load_addr_d        = load_addr_q + 4'd1;
                    if (wr_cnt_q != 5'(DEPTH)) begin
                        wr_cnt_d = wr_cnt_q + 5'd1;
                    end
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // NOTE: the program array is a flop array and is cleared on reset, because
    // the CPU must fetch NOPs (not garbage) straight out of reset and a reset
    // mid-load must discard a partial program.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            load_addr_q <= 4'd0;
            wr_cnt_q    <= 5'd0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= instr_t'(NOP_WORD);
            end
        end else begin
            state_q     <= state_d;
            load_addr_q <= load_addr_d;
            wr_cnt_q    <= wr_cnt_d;
            mem_q       <= mem_d;
        end
    end

    instr_t rd_word;

    always_comb begin
        rd_word = mem_q[bus.pc];
        if (state_q == ST_LOAD) begin
            rd_word = instr_t'(NOP_WORD);
        end
    end

    assign bus.opcode    = rd_word.op;
    assign bus.immediate = rd_word.imm;
    assign bus.cpu_hold  = (state_q == ST_LOAD);
    assign bus.load_addr = load_addr_q;
    // The counter saturates at the depth, so loaded stays set through wraps.
    assign bus.loaded    = (wr_cnt_q == 5'(DEPTH));

endmodule : td4_prog_mem

// File: tb/tb_td4_prog_mem.sv
// Directed self-checking bench for td4_prog_mem. Inputs are driven and
// outputs sampled on the falling clock edge.
module tb_td4_prog_mem;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    td4_prog_mem_if bus ();

    td4_prog_mem dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Strobe high 4 cycles, low 4 cycles; the write lands on the 3rd rising
    // edge after the strobe rise, well inside the high phase.
    task automatic pulse(input logic [7:0] data);
        bus.wr_data   = data;
        bus.wr_strobe = 1'b1;
        step(4);
        bus.wr_strobe = 1'b0;
        step(4);
    endtask

    task automatic read_at(input string tag, input logic [3:0] addr, input logic [7:0] exp);
        bus.pc = addr;
        #1;
        check(tag, {bus.immediate, bus.opcode}, exp);
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        bus.load_en   = 1'b0;
        bus.wr_strobe = 1'b0;
        bus.wr_data   = 8'h00;
        bus.pc        = 4'd5;

        // Reset state
        step(2);
        check("rst_opcode",    {4'h0, bus.opcode},    8'h00);
        check("rst_immediate", {4'h0, bus.immediate}, 8'h00);
        check("rst_cpu_hold",  {7'h0, bus.cpu_hold},  8'h00);
        check("rst_load_addr", {4'h0, bus.load_addr}, 8'h00);
        check("rst_loaded",    {7'h0, bus.loaded},    8'h00);
        rst_n = 1'b1;
        step(2);

        // Three writes, then back to RUN
        bus.load_en = 1'b1;
        step(4);
        check("load_hold", {7'h0, bus.cpu_hold}, 8'h01);
        pulse(8'h3B);
        pulse(8'hF0);
        pulse(8'h12);
        check("three_hold",   {7'h0, bus.cpu_hold},  8'h01);
        check("three_addr",   {4'h0, bus.load_addr}, 8'h03);
        check("three_loaded", {7'h0, bus.loaded},    8'h00);
        bus.load_en = 1'b0;
        step(4);
        check("run_hold", {7'h0, bus.cpu_hold}, 8'h00);
        read_at("run_pc0", 4'd0, 8'h3B);
        read_at("run_pc1", 4'd1, 8'hF0);
        read_at("run_pc2", 4'd2, 8'h12);
        read_at("run_pc3", 4'd3, 8'h00);

        // Full 16-word session, then a 17th write that wraps to address 0
        bus.load_en = 1'b1;
        step(4);
        check("reentry_addr",   {4'h0, bus.load_addr}, 8'h00);
        check("reentry_loaded", {7'h0, bus.loaded},    8'h00);
        for (int i = 0; i < 15; i++) pulse(8'(i));
        check("w15_addr",   {4'h0, bus.load_addr}, 8'h0F);
        check("w15_loaded", {7'h0, bus.loaded},    8'h00);
        bus.pc = 4'd3;
        #1;
        check("load_nop_out", {bus.immediate, bus.opcode}, 8'h00);
        bus.wr_data   = 8'h0F;
        bus.wr_strobe = 1'b1;
        step(2);
        check("w16_before_edge", {7'h0, bus.loaded}, 8'h00);
        step(1);
        check("w16_loaded", {7'h0, bus.loaded},    8'h01);
        check("w16_addr",   {4'h0, bus.load_addr}, 8'h00);
        step(1);
        bus.wr_strobe = 1'b0;
        step(4);
        pulse(8'hAA);
        check("w17_loaded", {7'h0, bus.loaded},    8'h01);
        check("w17_addr",   {4'h0, bus.load_addr}, 8'h01);
        bus.load_en = 1'b0;
        step(4);
        read_at("full_pc0",  4'd0,  8'hAA);
        read_at("full_pc1",  4'd1,  8'h01);
        read_at("full_pc15", 4'd15, 8'h0F);

        // Strobe already high at LOAD entry: only the later pulse writes
        bus.wr_data   = 8'h77;
        bus.wr_strobe = 1'b1;
        step(4);
        bus.load_en = 1'b1;
        step(4);
        check("held_entry_addr", {4'h0, bus.load_addr}, 8'h00);
        bus.wr_strobe = 1'b0;
        step(4);
        check("held_no_write", {4'h0, bus.load_addr}, 8'h00);
        pulse(8'h55);
        check("held_one_write", {4'h0, bus.load_addr}, 8'h01);
        bus.load_en = 1'b0;
        step(4);
        read_at("held_pc0", 4'd0, 8'h55);
        read_at("held_pc1", 4'd1, 8'h01);

        // Exit and strobe edge on the same synchronized cycle: exit wins
        bus.load_en = 1'b1;
        step(4);
        pulse(8'h99);
        bus.load_en   = 1'b0;
        bus.wr_data   = 8'hCC;
        bus.wr_strobe = 1'b1;
        step(4);
        check("race_hold", {7'h0, bus.cpu_hold},  8'h00);
        check("race_addr", {4'h0, bus.load_addr}, 8'h01);
        read_at("race_pc1", 4'd1, 8'h01);
        read_at("race_pc0", 4'd0, 8'h99);
        bus.wr_strobe = 1'b0;
        step(4);

        // Reset in the middle of a LOAD session
        bus.load_en = 1'b1;
        step(4);
        for (int i = 0; i < 5; i++) pulse(8'hE7);
        check("mid_addr", {4'h0, bus.load_addr}, 8'h05);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_hold", {7'h0, bus.cpu_hold},  8'h00);
        check("async_addr", {4'h0, bus.load_addr}, 8'h00);
        bus.load_en = 1'b0;
        step(1);
        for (int a = 0; a < 16; a++) read_at($sformatf("clr_pc%0d", a), 4'(a), 8'h00);
        rst_n = 1'b1;
        step(2);
        bus.load_en = 1'b1;
        step(4);
        check("post_rst_hold",   {7'h0, bus.cpu_hold},  8'h01);
        check("post_rst_addr",   {4'h0, bus.load_addr}, 8'h00);
        check("post_rst_loaded", {7'h0, bus.loaded},    8'h00);
        bus.load_en = 1'b0;
        step(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_td4_prog_mem

// File: doc/td4_prog_mem.md
# td4_prog_mem

Writable 16×8 program memory and instruction-fetch stage for the TD4 CPU. Sits directly upstream of the CPU core: indexes its contents with the CPU's 4-bit program counter and supplies the opcode/immediate pair each cycle. A pin-driven LOAD mode fills the memory byte-by-byte via a strobe handshake, and holds the CPU while loading is in progress.

## Interface

Parameters:
- DEPTH, 16, number of program words; fixed to the 4-bit PC range.
- NOP_WORD, 8'h00, word driven on the instruction outputs during LOAD and after reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- load_en  input  1  from pin, asynchronous; high requests LOAD mode.
- wr_strobe  input  1  from pin, asynchronous; each rising edge writes one byte in LOAD.
- wr_data  input  8  byte to write; [3:0] = opcode, [7:4] = immediate.
- pc  input  4  CPU program counter.
- opcode  output  4  instruction opcode to the CPU.
- immediate  output  4  instruction immediate to the CPU.
- cpu_hold  output  1  high while in LOAD; the CPU must not advance.
- load_addr  output  4  next address to be written.
- loaded  output  1  high once all 16 words have been written in the current LOAD session.

## Operation

- `load_en` and `wr_strobe` are each passed through a 2-flop synchronizer.
- `wr_strobe` additionally gets a rising-edge detector (previous-value flop).
- Edge-detector history updates every cycle in every state.
- Two-state FSM:
  - RUN → LOAD when synced `load_en` = 1.
  - LOAD → RUN when synced `load_en` = 0.
- RUN:
  - `opcode` = mem[pc][3:0], `immediate` = mem[pc][7:4], combinational from `pc`.
  - Strobe edges are ignored.
  - `cpu_hold` = 0.
- LOAD:
  - Instruction outputs = NOP_WORD; `cpu_hold` = 1.
  - On each strobe edge: mem[load_addr] ← wr_data; `load_addr` increments mod 16 (15 → 0 wraps); a 5-bit write counter increments and saturates at 16.
  - `loaded` = 1 when the counter reaches 16. Further writes still occur (overwrite from address 0 after wrap); `loaded` stays 1.
- On every RUN → LOAD transition: `load_addr` ← 0, counter ← 0, `loaded` ← 0.
- Simultaneous exit and strobe edge (synced `load_en` = 0 in the same cycle as the edge): exit wins, no write.
- Strobe already high at LOAD entry: no edge, no write. A low-then-high transition is required.
- Memory contents persist across LOAD→RUN and RUN→LOAD; only reset clears them.
- Reset, any state, asynchronous:
  - All 16 words ← NOP_WORD; FSM → RUN.
  - `load_addr` = 0, counter = 0, `loaded` = 0, `cpu_hold` = 0.
  - Synchronizer and edge flops ← 0.
  - `opcode` = 0, `immediate` = 0.
- Reset mid-LOAD discards partial contents; the next session restarts at address 0.

## Timing

- `load_en` pin change → state change: 2 cycles of synchronization, state updated on the 3rd rising edge; `cpu_hold` follows the state register.
- `wr_strobe` pin rise → write on the 3rd rising edge. `load_addr`, counter and `loaded` update on the same edge.
- `wr_data` is not synchronized. It must be stable from the strobe rise through 4 clock cycles after it.
- Minimum strobe high time and low time: 3 cycles each.
- RUN read: zero-cycle latency from `pc`. A write is visible on outputs only after returning to RUN.

## Structure

- Shared package `td4_pkg`:
  - state enum {ST_RUN, ST_LOAD}
  - constants PROG_DEPTH = 16, NOP_WORD = 8'h00
  - typedef `instr_t` (8-bit, fields imm[7:4] / op[3:0])
- One sub-module: `sync_rise`. It contains the 2-flop synchronizer plus rising-edge detector, asynchronous active-low reset to 0, and outputs `level` and `rise`. Instantiated twice; the `rise` output of the `load_en` instance is unused.
- Memory is a flop array, not a macro.

## Test plan

- Reset with pc = 5 → opcode = 0, immediate = 0, cpu_hold = 0, load_addr = 0, loaded = 0.
- Raise load_en, then pulse the strobe 3× with data 8'h3B, 8'hF0, 8'h12 → cpu_hold = 1, load_addr = 3, loaded = 0. Drop load_en; after 3 cycles pc = 0 gives opcode = 4'hB, immediate = 4'h3; pc = 2 gives opcode = 4'h2, immediate = 4'h1; pc = 3 gives 0/0.
- 16 pulses with data = address → loaded rises on the 16th write edge and load_addr = 0. A 17th pulse with 8'hAA → mem[0] = 8'hAA, loaded stays 1.
- Strobe held high while load_en rises, then strobe released and pulsed once with 8'h55 → exactly one write, at address 0.
- Strobe edge and load_en fall arrive on the same synced cycle → no write, state RUN, load_addr unchanged.
- rst_n asserted mid-LOAD after 5 writes → immediate asynchronous return to RUN; all words read 8'h00; cpu_hold = 0.
